// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Decode-stage <-> multiply/divide unit connection.
//   master (decode side) drives: start, op, regaData, regbData, whi, wlo, wdata
//   slave  (muldiv_unit)  drives: busy, stall, done, hi, lo
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [5:0]       op;
    logic [WIDTH-1:0] regaData;
    logic [WIDTH-1:0] regbData;
    logic             whi;
    logic             wlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, regaData, regbData, whi, wlo, wdata,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, regaData, regbData, whi, wlo, wdata,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO registers.
//   mult/multu: shift-add, one multiplier bit per cycle (LSB first).
//   div/divu:   restoring division, one quotient bit per cycle (MSB first).
//   Latency is WIDTH+1 edges from acceptance to HI/LO update.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - muldiv_unit_if.slave: start/op/regaData/regbData in,
//          whi/wlo/wdata (mthi/mtlo) in, busy/stall/done/hi/lo out
module muldiv_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [5:0] OP_MULT  = 6'h18,
    parameter logic [5:0] OP_MULTU = 6'h19,
    parameter logic [5:0] OP_DIV   = 6'h1a,
    parameter logic [5:0] OP_DIVU  = 6'h1b
) (
    input logic           clk,
    input logic           rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;          // |multiplicand|
    logic [WIDTH-1:0]   b_q, b_d;          // |divisor|
    logic [WIDTH-1:0]   orig_a_q, orig_a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper, lower} working register
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_mul, op_div, op_signed, accept, last_iter;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign accept    = (state_q == S_IDLE) && bus.start && (op_mul || op_div);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // The most negative value maps to itself, which reads correctly as unsigned.
    assign a_abs = (op_signed && bus.regaData[WIDTH-1]) ? -bus.regaData : bus.regaData;
    assign b_abs = (op_signed && bus.regbData[WIDTH-1]) ? -bus.regbData : bus.regbData;

    // Multiply step: add multiplicand into the upper half, carry kept for the shift.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    // Divide step: partial remainder shifted left with the next dividend bit.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    assign prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = op_div ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:  if (last_iter) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy  = (state_q != S_IDLE);
        bus.stall = (state_q != S_IDLE);
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        orig_a_d = orig_a_q;
        acc_d    = acc_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.whi) hi_d = bus.wdata;
                if (bus.wlo) lo_d = bus.wdata;
                if (accept) begin
                    cnt_d    = '0;
                    a_d      = a_abs;
                    b_d      = b_abs;
                    orig_a_d = bus.regaData;
                    sign_a_d = op_signed && bus.regaData[WIDTH-1];
                    sign_b_d = op_signed && bus.regbData[WIDTH-1];
                    is_div_d = op_div;
                    // Multiply seeds the low half with the multiplier, divide with the dividend.
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CW'(1);
                if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            S_DIV: begin
                cnt_d = cnt_q + CW'(1);
                if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            S_FIN: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = orig_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            orig_a_q <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            orig_a_q <= orig_a_d;
            acc_q    <= acc_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Table-driven checks of muldiv_unit results with a scoreboard queue of
//   expected {hi, lo}, plus hand sequences for mthi/mtlo, ignored starts,
//   and reset during an operation.
module tb_muldiv_unit;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1a;
    localparam logic [5:0] OP_DIVU  = 6'h1b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH(32),
        .OP_MULT(OP_MULT),
        .OP_MULTU(OP_MULTU),
        .OP_DIV(OP_DIV),
        .OP_DIVU(OP_DIVU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi, model_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a start for one edge (E0); returns #1 after E0.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.regaData = a;
        bus.regbData = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait for done, checking busy stays high and the 33-edge latency.
    // inject=1 pulses a different start at E5 and checks hi during busy.
    task automatic await_result(input string name, input bit inject);
        int   cycles = 0;
        bit   busy_ok = 1'b1;
        logic [63:0] exp;
        while (bus.done !== 1'b1 && cycles < 60) begin
            if (bus.busy !== 1'b1 || bus.stall !== 1'b1) busy_ok = 1'b0;
            if (inject && cycles == 4) begin
                bus.start    = 1'b1;
                bus.op       = OP_DIVU;
                bus.regaData = 32'd1000;
                bus.regbData = 32'd3;
            end
            if (inject && cycles == 5) bus.start = 1'b0;
            if (inject && cycles == 10) check({name, "_hi_busy"}, {32'h0, bus.hi}, {32'h0, model_hi});
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.whi = 1'b0;
        bus.wlo = 1'b0;
        check({name, "_busy_held"}, {63'h0, busy_ok}, 64'h1);
        check({name, "_latency"}, 64'(cycles), 64'd33);
        check({name, "_busy_low"}, {63'h0, bus.busy}, 64'h0);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'h1, 64'h0);
        end else begin
            exp = sb_q.pop_front();
            check({name, "_hilo"}, {bus.hi, bus.lo}, exp);
            model_hi = exp[63:32];
            model_lo = exp[31:0];
        end
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, {63'h0, bus.done}, 64'h0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg",    OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_neg",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_zero",   OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"multu_small", OP_MULTU, 32'd3,        32'd5,        32'h00000000, 32'h0000000F};
        vecs[6]  = '{"divu_rem",    OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[7]  = '{"div_negdiv",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{"mult_minm1",  OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{"div_zero_s",  OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[11] = '{"divu_big",    OP_DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF};

        bus.start = 1'b0; bus.op = '0; bus.regaData = '0; bus.regbData = '0;
        bus.whi = 1'b0; bus.wlo = 1'b0; bus.wdata = '0;
        model_hi = '0; model_lo = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_done", {63'h0, bus.done}, 64'h0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            sb_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
            check({vecs[i].name, "_busy_e0"}, {63'h0, bus.busy}, 64'h1);
            await_result(vecs[i].name, 1'b0);
        end

        // mthi in IDLE
        @(negedge clk);
        bus.whi = 1'b1; bus.wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.whi = 1'b0;
        model_hi = 32'h12345678;
        check("mthi_idle", {bus.hi, bus.lo}, {model_hi, model_lo});

        // mtlo in IDLE
        @(negedge clk);
        bus.wlo = 1'b1; bus.wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        bus.wlo = 1'b0;
        model_lo = 32'hAABBCCDD;
        check("mtlo_idle", {bus.hi, bus.lo}, {model_hi, model_lo});

        // start with a non-muldiv op is ignored
        issue(6'h00, 32'd9, 32'd9);
        check("bad_op_busy", {63'h0, bus.busy}, 64'h0);
        check("bad_op_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

        // whi held through the whole op, second start at E5: both ignored
        issue(OP_MULTU, 32'd6, 32'd7);
        sb_q.push_back({32'h0, 32'd42});
        bus.whi = 1'b1; bus.wdata = 32'hDEADBEEF;
        await_result("busy_ignore", 1'b1);

        // reset at E10 of a mult
        issue(OP_MULT, 32'd11, 32'd13);
        sb_q.push_back({32'h0, 32'd143});
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("midrst_busy", {63'h0, bus.busy}, 64'h0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
        begin
            bit saw_done = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) saw_done = 1'b1;
            end
            check("midrst_nodone", {63'h0, saw_done}, 64'h0);
        end

        // unit works again after the reset
        issue(OP_DIVU, 32'd81, 32'd9);
        sb_q.push_back({32'h0, 32'd9});
        await_result("post_rst", 1'b0);

        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
